// File: rtl/mem_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and
// data load/store. Data normally wins; a saturating counter forces fetch through.
module mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state_reg, state_next;
    logic [3:0] starve_cnt_reg, starve_cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= 4'd0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // Grants are only ever issued from IDLE, and never both in one cycle.
    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        d_gnt           = 1'b0;
        if_gnt          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (d_req && !(if_req && starve_cnt_reg == LIMIT)) begin
                    d_gnt      = 1'b1;
                    state_next = BUSY_D;
                    if (if_req && starve_cnt_reg < LIMIT)
                        starve_cnt_next = starve_cnt_reg + 4'd1;
                end else if (if_req) begin
                    if_gnt          = 1'b1;
                    state_next      = BUSY_IF;
                    starve_cnt_next = 4'd0;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (mem_ack)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if (d_gnt) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_be    <= d_be;
            end else if (if_gnt) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_be    <= '1;
            end
            // Acks seen in IDLE are stray and deliberately ignored.
            if (state_reg == BUSY_IF && mem_ack) begin
                mem_req   <= 1'b0;
                if_rvalid <= 1'b1;
                if_rdata  <= mem_rdata;
            end
            if (state_reg == BUSY_D && mem_ack) begin
                mem_req  <= 1'b0;
                d_rvalid <= 1'b1;
                if (!mem_we)
                    d_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store with waits, loads, priority,
// stray ack and asynchronous reset during an access.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_be = 0; mem_ack = 0; mem_rdata = 0;
        #3;
        check("rst_mem_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rvalid", {if_rvalid, d_rvalid}, 0);
        step();
        rst = 1'b0;

        // Single fetch, ack in the first busy cycle
        step();
        if_req = 1; if_addr = 32'h100; #1;
        check("fetch_if_gnt", if_gnt, 1);
        check("fetch_d_gnt", d_gnt, 0);
        step();
        if_req = 0; mem_ack = 1; mem_rdata = 32'hDEADBEEF; #1;
        check("fetch_mem_req", mem_req, 1);
        check("fetch_mem_addr", mem_addr, 32'h100);
        check("fetch_mem_we", mem_we, 0);
        check("fetch_mem_be", mem_be, 4'hF);
        check("fetch_no_gnt_busy", if_gnt, 0);
        step();
        mem_ack = 0; mem_rdata = 0; #1;
        check("fetch_if_rvalid", if_rvalid, 1);
        check("fetch_if_rdata", if_rdata, 32'hDEADBEEF);
        check("fetch_idle", busy, 0);
        check("fetch_mem_req_drop", mem_req, 0);
        step();
        check("fetch_rvalid_pulse", if_rvalid, 0);

        // Store with three wait states
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'h12345678; d_be = 4'b0011; #1;
        check("st_d_gnt", d_gnt, 1);
        for (int c = 1; c <= 4; c++) begin
            step();
            d_req = 0; d_addr = 32'hFFFF; d_wdata = 0; d_be = 0;
            mem_ack = (c == 4); mem_rdata = 32'hAAAA5555; #1;
            check($sformatf("st_cmd_c%0d", c),
                  {mem_req, mem_we, mem_be, mem_addr, mem_wdata[23:0]},
                  {1'b1, 1'b1, 4'b0011, 32'h2000, 24'h345678});
            check($sformatf("st_no_rvalid_c%0d", c), d_rvalid, 0);
        end
        step();
        mem_ack = 0; #1;
        check("st_d_rvalid", d_rvalid, 1);
        check("st_d_rdata_kept", d_rdata, 0);
        step();
        check("st_rvalid_pulse", d_rvalid, 0);

        // Back-to-back loads, ack held high, fetch idle
        d_we = 0;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) step();
            d_req = (c < 5); d_addr = 32'h300 + c; mem_ack = 1; mem_rdata = 32'h1000 + c; #1;
            check($sformatf("ld_d_gnt_c%0d", c), d_gnt, (c % 2 == 0 && c <= 4));
            check($sformatf("ld_rvalid_c%0d", c), d_rvalid, (c % 2 == 0 && c >= 2));
            if (c % 2 == 0 && c >= 2)
                check($sformatf("ld_rdata_c%0d", c), d_rdata, 32'h1000 + c - 1);
        end
        check("ld_starve_cnt", dut.starve_cnt_reg, 0);
        step();
        mem_ack = 0; d_req = 0;

        // Priority with both requests held: D D D D IF D D D D IF
        step();
        if_req = 1; if_addr = 32'h400; d_req = 1; d_we = 0; d_addr = 32'h500; mem_ack = 1; #1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin
                step();
                if (c == 19) begin if_req = 0; d_req = 0; end
                #1;
            end
            if (c % 2 == 0) begin
                check($sformatf("pri_d_gnt_%0d", c / 2), d_gnt, ((c / 2) % 5 != 4));
                check($sformatf("pri_if_gnt_%0d", c / 2), if_gnt, ((c / 2) % 5 == 4));
            end else begin
                check($sformatf("pri_none_c%0d", c), {d_gnt, if_gnt}, 0);
                if ((c / 2) % 5 == 4)
                    check($sformatf("pri_starve_clr_c%0d", c), dut.starve_cnt_reg, 0);
            end
        end
        step();
        mem_ack = 0; #1;
        check("pri_idle", busy, 0);

        // Stray ack in IDLE
        step();
        mem_ack = 1; mem_rdata = 32'h55; #1;
        step();
        mem_ack = 0; #1;
        check("stray_rvalid", {if_rvalid, d_rvalid}, 0);
        check("stray_busy", busy, 0);
        check("stray_mem_req", mem_req, 0);

        // Reset in the middle of a data access
        step();
        if_req = 1; if_addr = 32'h600; d_req = 1; d_we = 0; d_addr = 32'h700; #1;
        check("rr_d_gnt", d_gnt, 1);
        step();
        if_req = 0; d_req = 0; #1;
        check("rr_mem_req", mem_req, 1);
        check("rr_starve_one", dut.starve_cnt_reg, 1);
        #2 rst = 1'b1;
        #1;
        check("rr_mem_req_async", mem_req, 0);
        check("rr_busy_async", busy, 0);
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("rr_no_rvalid_c%0d", c), d_rvalid, 0);
            check($sformatf("rr_busy_c%0d", c), busy, 0);
        end
        check("rr_starve_cnt", dut.starve_cnt_reg, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
